signal_delayer_mc: RTL and testbench
====================================

# signal_delayer_mc

Multi-channel, parametrised successor to the single-channel signal delayer. Each channel qualifies its input with independent programmable rise and fall delays, rejecting glitches shorter than the programmed window. A per-channel mode selects either filter behaviour (output follows the qualified input) or stretch behaviour (one fixed-width pulse per qualified rising event). The block sits between synchronised status/strobe inputs and downstream control logic, replacing the separate delayer + pulse-stretcher pair.

## Interface
- CHANNELS, 4, number of independent channels (1..32)
- CNT_W, 8, width of delay values and per-channel counters
- clk  input  1  single clock; all state updates on rising edge
- rstn  input  1  reset, asynchronous assert, active-low
- sig_in  input  CHANNELS  per-channel input; must already be synchronous to clk
- en  input  CHANNELS  per-channel enable
- mode  input  CHANNELS  per-channel mode: 0 = FILTER, 1 = STRETCH
- rise_dly  input  CNT_W  rise qualification delay R, shared by all channels
- fall_dly  input  CNT_W  FILTER: fall qualification delay F; STRETCH: pulse width minus one
- sig_out  output  CHANNELS  qualified/delayed output, registered
- rise_pulse  output  CHANNELS  one-cycle strobe, high in the first cycle sig_out is high

## Operation
- Each channel has one FSM with states IDLE, RISE_WAIT, HIGH, FALL_WAIT, HOLD and REARM, plus a CNT_W-bit counter and a latched mode bit.
- sig_out is 1 exactly in HIGH, FALL_WAIT and HOLD.
- Counter compares use >= against the live rise_dly/fall_dly. A value lowered mid-count therefore ends the wait on the next sampled edge. Counters never wrap.
- IDLE:
  - sig_in=1 and R=0 goes to HIGH.
  - sig_in=1 and R>0 goes to RISE_WAIT with cnt=0.
- RISE_WAIT:
  - sig_in=0 goes to IDLE (glitch rejected).
  - sig_in=1 and cnt>=R-1 goes to HIGH.
  - Otherwise cnt++.
- Entry to HIGH: latch mode, set cnt=0, pulse rise_pulse.
- HIGH, latched mode FILTER:
  - sig_in=0 and F=0 goes to IDLE.
  - sig_in=0 and F>0 goes to FALL_WAIT with cnt=0.
  - sig_in=1 stays in HIGH.
- HIGH, latched mode STRETCH: go to HOLD if F>0; if F=0, apply the HOLD exit rule immediately.
- FALL_WAIT:
  - sig_in=1 goes back to HIGH, with no new rise_pulse.
  - sig_in=0 and cnt>=F-1 goes to IDLE.
  - Otherwise cnt++.
- HOLD:
  - cnt++ each cycle, ignoring sig_in.
  - When the pulse has been high F+1 cycles, exit: sig_in=1 goes to REARM, sig_in=0 goes to IDLE.
- REARM: sig_out=0; sig_in=0 goes to IDLE. A new pulse therefore needs a full low and a requalified rise.
- en=0: go to IDLE on the next edge and clear the counter, from any state.
- Changes to mode while a channel is asserted have no effect until the next HIGH entry.
- Channels are fully independent; no shared state except rise_dly and fall_dly.

## Timing
- Reset values: sig_out=0, rise_pulse=0, all FSMs IDLE, counters 0, latched mode 0. No clock is needed during reset.
- Rise latency: if sig_in is 1 at sampling edges E0..E0+R, sig_out and rise_pulse are high after edge E0+R. If sig_in is 0 at any of those edges, there is no assertion.
- FILTER fall latency: if sig_in is 0 at edges F0..F0+F, sig_out goes low after edge F0+F. With F=0, sig_out follows 1 cycle after the input drop.
- STRETCH: sig_out is high for exactly F+1 cycles per qualified rise, independent of input width.
- rise_pulse is high for exactly 1 cycle per IDLE→HIGH transition and never on FALL_WAIT→HIGH.
- Reset asserted mid-operation clears sig_out and rise_pulse immediately and asynchronously. After release, the first sampling edge evaluates from IDLE.
- Maximum delays: R=2^CNT_W−1 requires 2^CNT_W high samples. F likewise.

## Test plan
- Reset, then R=3, mode=0, F=2, ch0 sig_in high for 10 cycles from edge 0 -> sig_out[0] rises after edge 3; rise_pulse[0] is 1 cycle; sig_out[0] falls after edge 12.
- R=3, ch1 sig_in high for 3 cycles, low 1, high 6 -> no assertion on the first burst; sig_out[1] rises 3 edges after the second burst starts.
- FILTER, F=2, input already asserted, sig_in drops for 2 cycles -> sig_out stays 1 and no second rise_pulse.
- STRETCH, R=0, F=4, ch2 sig_in held high for 20 cycles -> sig_out[2] high for exactly 5 cycles, then 0 (REARM) until sig_in goes low and requalifies.
- Change R from 200 to 5 while ch3 is at cnt=50 in RISE_WAIT -> sig_out[3] rises on the next edge. Separately, drop en[3] while sig_out[3] is high -> 0 after one edge.
- All 4 channels active with mixed modes, rstn pulsed low mid-stretch -> all outputs 0 immediately; operation is clean after release.

Source files
------------

// File: rtl/signal_delayer_mc.sv
// Multi-channel signal delayer: per-channel rise/fall glitch qualification with
// a selectable filter (follow) or stretch (fixed-width pulse) output behaviour.
module signal_delayer_mc #(
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [CHANNELS-1:0] sig_in,
   input  logic [CHANNELS-1:0] en,
   input  logic [CHANNELS-1:0] mode,
   input  logic [CNT_W-1:0]    rise_dly,
   input  logic [CNT_W-1:0]    fall_dly,
   output logic [CHANNELS-1:0] sig_out,
   output logic [CHANNELS-1:0] rise_pulse
);

   localparam int unsigned EXT_W = CNT_W + 1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RISE_WAIT = 3'd1,
      HIGH      = 3'd2,
      FALL_WAIT = 3'd3,
      HOLD      = 3'd4,
      REARM     = 3'd5
   } state_t;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      state_t             state_q, state_d;
      logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_sat;
      logic [EXT_W-1:0]   cnt_inc;
      logic               mode_q, mode_d;
      logic               pulse_d;
      logic               out_q, pulse_q;
      logic               rise_done, fall_done;

      // cnt+1 >= dly is cnt >= dly-1 without underflow when a delay drops to 0
      assign cnt_inc   = EXT_W'(cnt_q) + EXT_W'(1);
      assign rise_done = (cnt_inc >= EXT_W'(rise_dly));
      assign fall_done = (cnt_inc >= EXT_W'(fall_dly));
      assign cnt_sat   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         mode_d  = mode_q;
         pulse_d = 1'b0;
         if (!en[c]) begin
            state_d = IDLE;
            cnt_d   = '0;
         end else begin
            case (state_q)
               IDLE: begin
                  cnt_d = '0;
                  if (sig_in[c]) begin
                     if (rise_dly == '0) begin
                        state_d = HIGH;
                        mode_d  = mode[c];
                        pulse_d = 1'b1;
                     end else begin
                        state_d = RISE_WAIT;
                     end
                  end
               end
               RISE_WAIT: begin
                  if (!sig_in[c]) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else if (rise_done) begin
                     state_d = HIGH;
                     cnt_d   = '0;
                     mode_d  = mode[c];
                     pulse_d = 1'b1;
                  end else begin
                     cnt_d = cnt_sat;
                  end
               end
               HIGH: begin
                  if (mode_q) begin
                     // First pulse cycle already spent in HIGH; zero width extension exits now
                     if (fall_dly != '0) state_d = HOLD;
                     else                state_d = sig_in[c] ? REARM : IDLE;
                  end else if (!sig_in[c]) begin
                     cnt_d   = '0;
                     state_d = (fall_dly == '0) ? IDLE : FALL_WAIT;
                  end
               end
               FALL_WAIT: begin
                  if (sig_in[c]) begin
                     state_d = HIGH;
                     cnt_d   = '0;
                  end else if (fall_done) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_sat;
                  end
               end
               HOLD: begin
                  if (fall_done) begin
                     state_d = sig_in[c] ? REARM : IDLE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_sat;
                  end
               end
               REARM: begin
                  if (!sig_in[c]) state_d = IDLE;
               end
               default: begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end
            endcase
         end
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            out_q   <= 1'b0;
            pulse_q <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            out_q   <= (state_d == HIGH) || (state_d == FALL_WAIT) || (state_d == HOLD);
            pulse_q <= pulse_d;
         end
      end

      assign sig_out[c]    = out_q;
      assign rise_pulse[c] = pulse_q;
   end

endmodule

// File: tb/tb_signal_delayer_mc.sv
// Directed bench for signal_delayer_mc: hand-derived expected output vectors are
// queued with each stimulus cycle and checked after the corresponding clock edge.
module tb_signal_delayer_mc;

   localparam int unsigned CH = 4;
   localparam int unsigned CW = 8;

   logic          clk;
   logic          rstn;
   logic [CH-1:0] sig_in;
   logic [CH-1:0] en;
   logic [CH-1:0] mode;
   logic [CW-1:0] rise_dly;
   logic [CW-1:0] fall_dly;
   logic [CH-1:0] sig_out;
   logic [CH-1:0] rise_pulse;

   typedef struct {
      string         tag;
      logic [CH-1:0] out;
      logic [CH-1:0] pulse;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   signal_delayer_mc #(.CHANNELS(CH), .CNT_W(CW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .sig_in    (sig_in),
      .en        (en),
      .mode      (mode),
      .rise_dly  (rise_dly),
      .fall_dly  (fall_dly),
      .sig_out   (sig_out),
      .rise_pulse(rise_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check_outputs(input string tag, input logic [CH-1:0] x_out,
                                input logic [CH-1:0] x_pulse);
      checks++;
      assert (sig_out === x_out) else begin
         errors++;
         $error("FAIL %s sig_out observed=%b expected=%b", tag, sig_out, x_out);
      end
      checks++;
      assert (rise_pulse === x_pulse) else begin
         errors++;
         $error("FAIL %s rise_pulse observed=%b expected=%b", tag, rise_pulse, x_pulse);
      end
   endtask

   // Drive one sampled cycle, queue its expectation, check after the edge
   task automatic step(input logic [CH-1:0] si, input logic [CH-1:0] e,
                       input logic [CH-1:0] md, input logic [CH-1:0] x_out,
                       input logic [CH-1:0] x_pulse, input string tag);
      exp_t item;
      exp_t got;
      sig_in = si;
      en     = e;
      mode   = md;
      item.tag   = tag;
      item.out   = x_out;
      item.pulse = x_pulse;
      exp_q.push_back(item);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      check_outputs(got.tag, got.out, got.pulse);
   endtask

   initial begin
      logic b;
      logic p;
      rstn     = 1'b0;
      sig_in   = '0;
      en       = '1;
      mode     = '0;
      rise_dly = 8'd3;
      fall_dly = 8'd2;

      // Reset state, before and across a clock edge
      #2;
      check_outputs("reset_noclk", 4'b0000, 4'b0000);
      #5;
      rstn = 1'b1;
      check_outputs("reset_held", 4'b0000, 4'b0000);

      // T1: FILTER R=3 F=2, ch0 high 10 cycles
      for (int k = 0; k < 14; k++) begin
         b = (k >= 3 && k <= 11);
         p = (k == 3);
         step({3'b000, (k < 10)}, 4'hF, 4'h0, {3'b000, b}, {3'b000, p},
              $sformatf("t1_k%0d", k));
      end

      // T2: ch1 glitch burst of 3 rejected, then qualified burst
      for (int k = 0; k < 14; k++) begin
         b = (k >= 7 && k <= 11);
         p = (k == 7);
         step({2'b00, ((k < 3) || (k >= 4 && k < 10)), 1'b0}, 4'hF, 4'h0,
              {2'b00, b, 1'b0}, {2'b00, p, 1'b0}, $sformatf("t2_k%0d", k));
      end

      // T3: FILTER F=2, two-cycle dropout is bridged without a new pulse
      for (int k = 0; k < 14; k++) begin
         b = (k >= 3 && k <= 11);
         p = (k == 3);
         step({3'b000, ((k < 6) || k == 8 || k == 9)}, 4'hF, 4'h0,
              {3'b000, b}, {3'b000, p}, $sformatf("t3_k%0d", k));
      end

      // T4: STRETCH R=0 F=4 on ch2, long input then requalified rise
      rise_dly = 8'd0;
      fall_dly = 8'd4;
      for (int k = 0; k < 33; k++) begin
         b = (k <= 4) || (k >= 23 && k <= 27);
         p = (k == 0) || (k == 23);
         step({1'b0, ((k < 20) || (k >= 23 && k <= 30)), 2'b00}, 4'hF, 4'b0100,
              {1'b0, b, 2'b00}, {1'b0, p, 2'b00}, $sformatf("t4_k%0d", k));
      end
      // T4b: single-cycle input still yields a 5-cycle pulse
      for (int k = 0; k < 8; k++) begin
         b = (k <= 4);
         p = (k == 0);
         step({1'b0, (k == 0), 2'b00}, 4'hF, 4'b0100,
              {1'b0, b, 2'b00}, {1'b0, p, 2'b00}, $sformatf("t4b_k%0d", k));
      end

      // T5: lower R mid-count on ch3, then drop enable while high
      rise_dly = 8'd200;
      fall_dly = 8'd2;
      for (int k = 0; k <= 50; k++)
         step(4'b1000, 4'hF, 4'h0, 4'b0000, 4'b0000, $sformatf("t5_wait_k%0d", k));
      rise_dly = 8'd5;
      step(4'b1000, 4'hF, 4'h0, 4'b1000, 4'b1000, "t5_r_lowered");
      for (int k = 0; k < 3; k++)
         step(4'b1000, 4'hF, 4'h0, 4'b1000, 4'b0000, $sformatf("t5_high_k%0d", k));
      step(4'b1000, 4'b0111, 4'h0, 4'b0000, 4'b0000, "t5_en_drop");
      step(4'b1000, 4'hF, 4'h0, 4'b0000, 4'b0000, "t5_en_back");
      step(4'b0000, 4'hF, 4'h0, 4'b0000, 4'b0000, "t5_low0");
      step(4'b0000, 4'hF, 4'h0, 4'b0000, 4'b0000, "t5_low1");

      // T6: all channels, mixed modes, async reset mid-stretch
      rise_dly = 8'd0;
      fall_dly = 8'd6;
      step(4'b1111, 4'hF, 4'b0101, 4'b1111, 4'b1111, "t6_pre_k0");
      step(4'b1111, 4'hF, 4'b0101, 4'b1111, 4'b0000, "t6_pre_k1");
      step(4'b1111, 4'hF, 4'b0101, 4'b1111, 4'b0000, "t6_pre_k2");
      #2;
      rstn = 1'b0;
      #1;
      check_outputs("t6_async_rst", 4'b0000, 4'b0000);
      @(posedge clk);
      #3;
      rstn = 1'b1;
      fall_dly = 8'd2;
      for (int k = 0; k < 10; k++) begin
         logic [CH-1:0] xo;
         if (k <= 2)      xo = 4'b1111;
         else if (k <= 7) xo = 4'b1010;
         else             xo = 4'b0000;
         step((k < 6) ? 4'b1111 : 4'b0000, 4'hF, 4'b0101, xo,
              (k == 0) ? 4'b1111 : 4'b0000, $sformatf("t6_post_k%0d", k));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
